// File: rtl/ucsbece154_icache.sv
// rtl/ucsbece154_icache.sv - direct-mapped read-only instruction cache with burst refill
//
// Purpose: serves word fetches from a NUM_SETS x BLOCK_WORDS line store; on a miss
// it requests a block-aligned burst from instruction memory, writes the
// MemDataReady-qualified words in order, then returns the requested word.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   ReadEnable/Address    fetch request, held by the caller until Ready
//   Flush                 invalidate all lines (honoured only while idle)
//   Instruction, Ready    fetched word and its one-cycle qualifier
//   MemReadRequest/Addr   burst request and block base address to memory
//   MemDataIn/DataReady   burst words from memory, one pulse per word
//
// Configuration: define ICACHE_EARLY_RESTART_EN to return the requested word the
// cycle after it arrives in the burst instead of after the whole line is written.

module ucsbece154_icache #(
    parameter int NUM_SETS    = 8,
    parameter int BLOCK_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReadEnable,
    input  logic [31:0] ReadAddress,
    input  logic        Flush,
    output logic [31:0] Instruction,
    output logic        Ready,
    output logic        MemReadRequest,
    output logic [31:0] MemReadAddress,
    input  logic [31:0] MemDataIn,
    input  logic        MemDataReady
);
    localparam int WORD_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W  = 2 + WORD_W;
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int CNT_W  = WORD_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_FILL, S_DELIVER} state_t;

    state_t              state_q, state_d;
    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:2]         miss_addr_q, miss_addr_d;
    logic [31:0]         instr_q, instr_d;
    logic                ready_q, ready_d;
    logic                req_q, req_d;
    logic [31:0]         maddr_q, maddr_d;

    logic [31:0]         line_mem [NUM_SETS][BLOCK_WORDS];
    logic [TAG_W-1:0]    tag_mem  [NUM_SETS];

    logic                mem_we, tag_we;
    logic [IDX_W-1:0]    rd_idx, miss_idx;
    logic [TAG_W-1:0]    rd_tag, miss_tag;
    logic [WORD_W-1:0]   rd_word, miss_word, fill_word;
    logic                hit, last_word;
    logic                addr_lsb_unused;

    // Byte-offset bits of the fetch address carry no information for a word cache.
    assign addr_lsb_unused = ^ReadAddress[1:0];

    assign rd_idx    = ReadAddress[OFF_W +: IDX_W];
    assign rd_tag    = ReadAddress[31 -: TAG_W];
    assign rd_word   = ReadAddress[2 +: WORD_W];
    assign miss_idx  = miss_addr_q[OFF_W +: IDX_W];
    assign miss_tag  = miss_addr_q[31 -: TAG_W];
    assign miss_word = miss_addr_q[2 +: WORD_W];
    assign fill_word = cnt_q[WORD_W-1:0];
    assign last_word = (cnt_q == CNT_W'(BLOCK_WORDS - 1));
    assign hit       = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        cnt_d       = cnt_q;
        miss_addr_d = miss_addr_q;
        instr_d     = instr_q;
        ready_d     = 1'b0;
        req_d       = req_q;
        maddr_d     = maddr_q;
        mem_we      = 1'b0;
        tag_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Flush wins over a same-cycle fetch; the fetch is re-seen next cycle.
                if (Flush) begin
                    valid_d = '0;
                end else if (ReadEnable) begin
                    if (hit) begin
                        ready_d = 1'b1;
                        instr_d = line_mem[rd_idx][rd_word];
                    end else begin
                        miss_addr_d = ReadAddress[31:2];
                        maddr_d     = {ReadAddress[31:OFF_W], {OFF_W{1'b0}}};
                        req_d       = 1'b1;
                        cnt_d       = '0;
                        state_d     = S_REQUEST;
                    end
                end
            end
            S_REQUEST, S_FILL: begin
                // The request stays up until memory starts the burst; the first
                // word is taken in the same cycle the request drops.
                if (MemDataReady) begin
                    mem_we = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    req_d  = 1'b0;
                    if (fill_word == miss_word) begin
                        instr_d = MemDataIn;
`ifdef ICACHE_EARLY_RESTART_EN
                        ready_d = 1'b1;
`endif
                    end
                    if (last_word) begin
                        tag_we            = 1'b1;
                        valid_d[miss_idx] = 1'b1;
`ifdef ICACHE_EARLY_RESTART_EN
                        state_d = S_IDLE;
`else
                        ready_d = 1'b1;
                        state_d = S_DELIVER;
`endif
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_DELIVER: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            cnt_q       <= '0;
            miss_addr_q <= '0;
            instr_q     <= '0;
            ready_q     <= 1'b0;
            req_q       <= 1'b0;
            maddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            miss_addr_q <= miss_addr_d;
            instr_q     <= instr_d;
            ready_q     <= ready_d;
            req_q       <= req_d;
            maddr_q     <= maddr_d;
        end
    end

    // Line data and tags need no reset: nothing is read unless its valid bit is set.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            line_mem[miss_idx][fill_word] <= MemDataIn;
        end
        if (tag_we) begin
            tag_mem[miss_idx] <= miss_tag;
        end
    end

    assign Instruction    = instr_q;
    assign Ready          = ready_q;
    assign MemReadRequest = req_q;
    assign MemReadAddress = maddr_q;

endmodule

// File: tb/tb_ucsbece154_icache.sv
// tb/tb_ucsbece154_icache.sv - self-checking bench for ucsbece154_icache

module tb_ucsbece154_icache;
    logic        clk = 1'b0;
    logic        reset;
    logic        ReadEnable;
    logic [31:0] ReadAddress;
    logic        Flush;
    logic [31:0] Instruction;
    logic        Ready;
    logic        MemReadRequest;
    logic [31:0] MemReadAddress;
    logic [31:0] MemDataIn;
    logic        MemDataReady;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: which block each set currently holds.
    bit          model_valid [8];
    logic [24:0] model_tag   [8];

`ifdef ICACHE_EARLY_RESTART_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    always #5 clk = ~clk;

    ucsbece154_icache dut (
        .clk            (clk),
        .reset          (reset),
        .ReadEnable     (ReadEnable),
        .ReadAddress    (ReadAddress),
        .Flush          (Flush),
        .Instruction    (Instruction),
        .Ready          (Ready),
        .MemReadRequest (MemReadRequest),
        .MemReadAddress (MemReadAddress),
        .MemDataIn      (MemDataIn),
        .MemDataReady   (MemDataReady)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Instruction memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] memword(input logic [31:0] addr);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic clear_model();
        for (int s = 0; s < 8; s++) model_valid[s] = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_instr"}, Instruction, 32'h0);
        check({tag, "_ready"}, {31'b0, Ready}, 32'h0);
        check({tag, "_req"}, {31'b0, MemReadRequest}, 32'h0);
        check({tag, "_maddr"}, MemReadAddress, 32'h0);
    endtask

    // One fetch; acts as the burst memory on a miss. abort_after>0 pulls reset
    // after that many burst words.
    task automatic fetch(input logic [31:0] addr, input int abort_after);
        logic [31:0] base;
        logic [24:0] tg;
        int          set, req_off, ready_word, gap;
        bit          hit;
        base    = {addr[31:4], 4'b0000};
        set     = int'(addr[6:4]);
        tg      = addr[31:7];
        req_off = int'(addr[3:2]);
        hit     = model_valid[set] && (model_tag[set] == tg);
        ReadEnable  = 1'b1;
        ReadAddress = addr;
        @(negedge clk);
        if (hit) begin
            check("hit_ready", {31'b0, Ready}, 32'h1);
            check("hit_instr", Instruction, memword(addr));
            check("hit_noreq", {31'b0, MemReadRequest}, 32'h0);
            return;
        end
        check("miss_ready", {31'b0, Ready}, 32'h0);
        check("miss_req", {31'b0, MemReadRequest}, 32'h1);
        check("miss_maddr", MemReadAddress, base);
        ready_word = EARLY ? req_off : 3;
        for (int i = 0; i < 4; i++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check("gap_ready", {31'b0, Ready}, 32'h0);
                check("gap_req", {31'b0, MemReadRequest}, (i == 0) ? 32'h1 : 32'h0);
            end
            MemDataReady = 1'b1;
            MemDataIn    = memword(base + 32'(4 * i));
            @(negedge clk);
            MemDataReady = 1'b0;
            MemDataIn    = $urandom;
            check("fill_ready", {31'b0, Ready}, (i == ready_word) ? 32'h1 : 32'h0);
            check("fill_req", {31'b0, MemReadRequest}, 32'h0);
            if (i == ready_word) begin
                check("fill_instr", Instruction, memword(addr));
                ReadEnable = 1'b0;
            end
            if (i + 1 == abort_after) begin
                reset = 1'b0;
                #1;
                check_all_zero("abort");
                clear_model();
                ReadEnable = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                return;
            end
        end
        model_valid[set] = 1'b1;
        model_tag[set]   = tg;
        if (!EARLY) begin
            @(negedge clk);
            check("post_deliver_ready", {31'b0, Ready}, 32'h0);
        end
    endtask

    task automatic flush_op(input logic [31:0] addr);
        Flush       = 1'b1;
        ReadEnable  = 1'b1;
        ReadAddress = addr;
        @(negedge clk);
        check("flush_ready", {31'b0, Ready}, 32'h0);
        check("flush_req", {31'b0, MemReadRequest}, 32'h0);
        Flush      = 1'b0;
        ReadEnable = 1'b0;
        clear_model();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'h00010000;
        a = a | (32'($urandom_range(0, 2)) << 7);
        a = a | (32'($urandom_range(0, 3)) << 4);
        a = a | (32'($urandom_range(0, 3)) << 2);
        a = a | 32'($urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        int r;
        reset        = 1'b0;
        ReadEnable   = 1'b0;
        ReadAddress  = 32'h0;
        Flush        = 1'b0;
        MemDataIn    = 32'h0;
        MemDataReady = 1'b0;
        clear_model();
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        fetch(32'h00010000, 0);
        fetch(32'h00010004, 0);
        fetch(32'h0001000C, 0);
        fetch(32'h0001008C, 0);
        fetch(32'h0001000C, 0);

        fetch(32'h00010000, 0);
        flush_op(32'h00010000);
        fetch(32'h00010000, 0);

        fetch(32'h00010040, 2);
        fetch(32'h00010000, 0);

        flush_op(32'h00010000);
        fetch(32'h00010004, 0);
        fetch(32'h00010008, 0);

        for (int n = 0; n < 120; n++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                flush_op(rand_addr());
            end else if (r == 1) begin
                ReadEnable = 1'b0;
                @(negedge clk);
                check("idle_ready", {31'b0, Ready}, 32'h0);
            end else if (r == 2) begin
                fetch(rand_addr(), int'($urandom_range(1, 3)));
            end else begin
                fetch(rand_addr(), 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
